// File: rtl/arm_sequencer_pkg.sv
// Shared opcode field encodings and sequencer state encodings for the ARM
// sequencer, its ALU and their testbenches.
package arm_defs;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'b00,
        ST_EXEC1  = 2'b01,
        ST_LDWAIT = 2'b10,
        ST_HALT   = 2'b11
    } state_e;

    // inst[15] selects an ALU (arm) op; otherwise inst[14:12] is a control sub-op
    localparam int unsigned ARM_BIT = 15;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_B    = 3'b001;
    localparam logic [2:0] OP_BZ   = 3'b010;
    localparam logic [2:0] OP_BNZ  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

endpackage

// File: rtl/arm_sequencer.sv
// Instruction sequencer: fetch/execute loop with load stall, PC-relative
// branches on the registered zero flag, and an absorbing HALT.
module arm_sequencer
    import arm_defs::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] inst,
    output logic        exec1,
    input  logic [15:0] alu_out,
    input  logic        ldr,
    input  logic        dmem_ack,
    output logic        stall,
    output logic        zflag,
    output logic        halted
);

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] inst_q, inst_d;
    logic        zflag_q, zflag_d;
    logic        take;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            zflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            zflag_q <= zflag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        zflag_d = zflag_q;
        take    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                inst_d  = imem_data;
                pc_d    = pc_q + 16'd1;
                state_d = ST_EXEC1;
            end
            ST_EXEC1: begin
                // A load decode takes priority over the arm/control split
                if (ldr) begin
                    state_d = ST_LDWAIT;
                end else if (inst_q[ARM_BIT]) begin
                    zflag_d = (alu_out == 16'h0000);
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_FETCH;
                    case (inst_q[14:12])
                        OP_B:    take = 1'b1;
                        OP_BZ:   take = zflag_q;
                        OP_BNZ:  take = ~zflag_q;
                        OP_HALT: state_d = ST_HALT;
                        default: take = 1'b0;
                    endcase
                    // PC already points past the branch; offset is sign-extended
                    if (take) pc_d = pc_q + {{8{inst_q[7]}}, inst_q[7:0]};
                end
            end
            ST_LDWAIT: begin
                if (dmem_ack) state_d = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    assign imem_addr = pc_q;
    assign inst      = inst_q;
    assign zflag     = zflag_q;
    assign exec1     = (state_q == ST_EXEC1);
    assign stall     = (state_q == ST_LDWAIT);
    assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_arm_sequencer.sv
// Directed bench for arm_sequencer: ALU op, load stall, branches, PC wrap,
// HALT and reset override, with hand-computed expectations.
module tb_arm_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] alu_out;
    logic        ldr;
    logic        dmem_ack;

    logic [15:0] imem_addr, imem_data, inst;
    logic        exec1, stall, zflag, halted;

    logic [15:0] w_imem_addr, w_imem_data, w_inst;
    logic        w_exec1, w_stall, w_zflag, w_halted;

    logic [15:0] imem [0:255];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign imem_data   = imem[imem_addr[7:0]];
    assign w_imem_data = imem[w_imem_addr[7:0]];

    arm_sequencer dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
        .inst(inst), .exec1(exec1), .alu_out(alu_out), .ldr(ldr),
        .dmem_ack(dmem_ack), .stall(stall), .zflag(zflag), .halted(halted)
    );

    arm_sequencer #(.RESET_PC(16'hFFFF)) dut_w (
        .clk(clk), .rst(rst), .imem_addr(w_imem_addr), .imem_data(w_imem_data),
        .inst(w_inst), .exec1(w_exec1), .alu_out(alu_out), .ldr(ldr),
        .dmem_ack(dmem_ack), .stall(w_stall), .zflag(w_zflag), .halted(w_halted)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    endtask

    initial begin
        rst = 1'b0; alu_out = 16'h0000; ldr = 1'b0; dmem_ack = 1'b0;
        clear_imem();

        // ALU op with zero result
        imem[0] = 16'h8123;
        alu_out = 16'h0000;
        do_reset();
        chk("rst_addr",   imem_addr, 16'h0000);
        chk("rst_inst",   inst, 16'h0000);
        chk("rst_zflag",  {15'd0, zflag}, 16'd0);
        chk("rst_exec1",  {15'd0, exec1}, 16'd0);
        chk("rst_stall",  {15'd0, stall}, 16'd0);
        chk("rst_halted", {15'd0, halted}, 16'd0);
        chk("w_rst_addr", w_imem_addr, 16'hFFFF);
        tick();
        chk("alu_inst",   inst, 16'h8123);
        chk("alu_exec1",  {15'd0, exec1}, 16'd1);
        chk("alu_pc1",    imem_addr, 16'h0001);
        tick();
        chk("alu_zflag",  {15'd0, zflag}, 16'd1);
        chk("alu_exec1_off", {15'd0, exec1}, 16'd0);
        chk("alu_addr3",  imem_addr, 16'h0001);

        // Load stall: ack arrives in the third LDWAIT cycle
        do_reset();
        tick();
        ldr = 1'b1; dmem_ack = 1'b1;   // ack outside LDWAIT must be ignored
        tick();
        ldr = 1'b0; dmem_ack = 1'b0;
        chk("ld_stall1", {15'd0, stall}, 16'd1);
        tick();
        chk("ld_stall2", {15'd0, stall}, 16'd1);
        tick();
        chk("ld_stall3", {15'd0, stall}, 16'd1);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        chk("ld_stall_off", {15'd0, stall}, 16'd0);
        chk("ld_addr",  imem_addr, 16'h0001);
        chk("ld_zflag", {15'd0, zflag}, 16'd0);
        chk("ld_exec1", {15'd0, exec1}, 16'd0);

        // Branches at address 5 after five leading instructions
        clear_imem();
        imem[5] = 16'h10FE;
        do_reset();
        repeat (12) tick();
        chk("b_back", imem_addr, 16'h0004);

        imem[5] = 16'h2003;
        do_reset();
        repeat (12) tick();
        chk("bz_nt", imem_addr, 16'h0006);

        imem[5] = 16'h3003;
        do_reset();
        repeat (12) tick();
        chk("bnz_t", imem_addr, 16'h0009);

        imem[0] = 16'h8000;
        imem[5] = 16'h2003;
        alu_out = 16'h0000;
        do_reset();
        repeat (12) tick();
        chk("bz_t", imem_addr, 16'h0009);
        chk("bz_t_z", {15'd0, zflag}, 16'd1);

        imem[5] = 16'h3003;
        do_reset();
        repeat (12) tick();
        chk("bnz_nt", imem_addr, 16'h0006);

        imem[0] = 16'h8000;
        imem[5] = 16'h5003;            // unassigned sub-op acts as NOP
        alu_out = 16'h0042;
        do_reset();
        repeat (12) tick();
        chk("undef_nop", imem_addr, 16'h0006);
        chk("nz_zflag",  {15'd0, zflag}, 16'd0);

        // Wrap on the RESET_PC=FFFF instance
        clear_imem();
        imem[0] = 16'h1080;
        do_reset();
        chk("w_rst", w_imem_addr, 16'hFFFF);
        repeat (2) tick();
        chk("w_wrap", w_imem_addr, 16'h0000);
        chk("w_wrap_z", {15'd0, w_zflag}, 16'd0);
        repeat (2) tick();
        chk("w_b80", w_imem_addr, 16'hFF81);

        // HALT at address 2 is absorbing
        clear_imem();
        imem[2] = 16'h7000;
        alu_out = 16'h0000;
        do_reset();
        repeat (6) tick();
        chk("halt_flag", {15'd0, halted}, 16'd1);
        chk("halt_addr", imem_addr, 16'h0003);
        for (int c = 0; c < 20; c++) begin
            dmem_ack = c[0];
            ldr      = c[1];
            tick();
            chk("halt_hold_addr", imem_addr, 16'h0003);
            chk("halt_hold_flag", {15'd0, halted}, 16'd1);
            chk("halt_hold_ex",   {14'd0, exec1, stall}, 16'd0);
        end
        ldr = 1'b0; dmem_ack = 1'b0;
        chk("halt_inst",  inst, 16'h7000);
        chk("halt_zflag", {15'd0, zflag}, 16'd0);
        do_reset();
        chk("halt_rst", {15'd0, halted}, 16'd0);
        chk("halt_rst_addr", imem_addr, 16'h0000);

        // Reset while waiting on a load
        imem[0] = 16'h8000;
        tick();
        ldr = 1'b1;
        tick();
        ldr = 1'b0;
        chk("ldr_stall", {15'd0, stall}, 16'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ldr_rst_stall", {15'd0, stall}, 16'd0);
        chk("ldr_rst_addr",  imem_addr, 16'h0000);
        chk("ldr_rst_inst",  inst, 16'h0000);
        tick();
        chk("ldr_rst_fetch", {15'd0, exec1}, 16'd1);
        chk("ldr_rst_pc",    imem_addr, 16'h0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/arm_sequencer.md
ARM_SEQUENCER -- requirements
Module: arm_sequencer

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 imem_addr  output  16  instruction memory address, equal to PC.
REQ-005 imem_data  input  16  instruction word, combinational read of imem_addr.
REQ-006 inst  output  16  instruction register, driven to the ALU instruction input.
REQ-007 exec1  output  1  one-cycle execute strobe to the ALU.
REQ-008 alu_out  input  16  ALU result, the ALU d_out.
REQ-009 ldr  input  1  ALU load-decode flag.
REQ-010 dmem_ack  input  1  data memory completion for a load.
REQ-011 stall  output  1  high while waiting on dmem_ack.
REQ-012 zflag  output  1  registered zero flag.
REQ-013 halted  output  1  high in HALT state.

Function
REQ-014 The FSM SHALL have the states FETCH, EXEC1, LDWAIT and HALT, with exactly one state active per cycle.
REQ-015 FETCH SHALL last one cycle, load inst<=imem_data and PC<=PC+1 (mod 2^16), then go to EXEC1.
REQ-016 In EXEC1, exec1 SHALL be 1; in every other state it SHALL be 0.
REQ-017 In EXEC1 with inst[15]=1 and ldr=0, the block SHALL load zflag<=(alu_out==16'h0000) and go to FETCH.
REQ-018 In EXEC1 with ldr=1, the block SHALL go to LDWAIT and leave zflag unchanged.
REQ-019 In LDWAIT, stall SHALL be 1, and the block SHALL stay in LDWAIT until dmem_ack=1, then go to FETCH on the next edge; a dmem_ack while in any other state SHALL be ignored.
REQ-020 In EXEC1 with inst[15]=0, the block SHALL decode inst[14:12] as follows:
  - 000 NOP
  - 001 B: unconditional branch
  - 010 BZ: branch if zflag=1
  - 011 BNZ: branch if zflag=0
  - 111 HALT: go to HALT
  - other values: treated as NOP
REQ-021 A taken branch SHALL set PC<=PC+sext(inst[7:0]); PC already points past the branch, so the effective target is branch_addr+1+offset, modulo 2^16 with silent wrap.
REQ-022 A not-taken branch or a NOP SHALL leave PC unchanged and go to FETCH; none of these SHALL modify zflag.
REQ-023 HALT SHALL be absorbing: PC, inst and zflag frozen, halted=1, exit only via rst.
REQ-024 PC wrap SHALL be silent: 16'hFFFF+1 -> 16'h0000, with no flag.
REQ-025 imem_addr SHALL equal PC combinationally in all states.
REQ-026 CPI SHALL be 2 for ALU ops, branches and NOPs, and 2+N for a load whose dmem_ack arrives N cycles after entering LDWAIT (N>=1).

Reset
REQ-027 On a clk edge with rst=1, the block SHALL set state=FETCH, PC=RESET_PC, inst=16'h0000, zflag=0, exec1=0, stall=0 and halted=0.
REQ-028 rst SHALL override every state, including a pending LDWAIT and HALT, and SHALL discard any in-flight load without waiting for dmem_ack.
REQ-029 The first FETCH SHALL occur in the first cycle with rst=0.

Structure
REQ-030 The opcode field encodings (arm bit, branch sub-ops, HALT) and the 2-bit state encodings SHALL live in a shared package, arm_defs, also used by the ALU and its testbench.
REQ-031 The block SHALL be a single module with no sub-modules; the next-PC adder and sign-extension SHALL be inline.

Verification
REQ-032 ALU op: rst release, imem[0]=16'h8xxx, alu_out=0 in EXEC1 -> inst captured in cycle 1, exec1 in cycle 2, zflag=1, imem_addr=1 at cycle 3.
REQ-033 Load stall: imem[0] with ldr=1, dmem_ack asserted 3 cycles after LDWAIT entry -> stall high for exactly 3 cycles, next FETCH at addr 1, zflag unchanged.
REQ-034 Branches: at addr 5, B with offset 8'hFE -> next fetch addr 4; BZ with zflag=0 -> next fetch addr 6; BNZ with zflag=0 and offset 8'h03 -> next fetch addr 9.
REQ-035 Wrap: RESET_PC=16'hFFFF with a NOP -> second fetch at addr 16'h0000; B at 16'h0000 with offset 8'h80 -> next fetch at 16'hFF81.
REQ-036 HALT and reset: HALT at addr 2 -> halted=1, imem_addr=3 frozen for 20 cycles, dmem_ack pulses ignored; rst asserted mid-LDWAIT -> next cycle state FETCH, PC=RESET_PC, stall=0.
